// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM stage: FSM states,
// access sizes and byte-lane patterns.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RD  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    // Byte wins when both size flags are set.
    function automatic size_e dec_size(input logic lsb, input logic lsh);
        if (lsb) return SZ_B;
        if (lsh) return SZ_H;
        return SZ_W;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store replication and enables,
// load shift and sign/zero extension.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  size_e       size_i,
    input  logic [1:0]  off_i,
    input  logic        signext_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] dmem_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic [31:0] load_o
);

    logic [1:0]  eoff;
    logic [31:0] sh;

    // Halves use only off[1]; words ignore the offset entirely.
    always_comb begin
        eoff = off_i;
        if (size_i == SZ_H) begin
            eoff[0] = 1'b0;
        end else if (size_i != SZ_B) begin
            eoff = 2'b00;
        end
    end

    assign sh = rdata_i >> {eoff, 3'b000};

    always_comb begin
        wdata_o = dmem_i;
        be_o    = data_be_i;
        load_o  = rdata_i;
        unique case (size_i)
            SZ_B: begin
                wdata_o = {4{dmem_i[7:0]}};
                be_o    = BE_B << eoff;
                load_o  = {{24{signext_i & sh[7]}}, sh[7:0]};
            end
            SZ_H: begin
                wdata_o = {2{dmem_i[15:0]}};
                be_o    = BE_H << eoff;
                load_o  = {{16{signext_i & sh[15]}}, sh[15:0]};
            end
            default: begin
                wdata_o = dmem_i;
                be_o    = data_be_i;
                load_o  = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory req/gnt/rvalid handshake, lane alignment, MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN adds o_wb_misalign and suppresses misaligned accesses.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_resetn,
    input  logic          i_mem_mem2reg,
    input  logic          i_mem_wmem,
    input  logic          i_mem_wreg,
    input  logic          i_mem_loadsignext,
    input  logic          i_mem_lsb,
    input  logic          i_mem_lsh,
    input  logic [3:0]    i_data_be,
    input  logic [4:0]    i_mem_rd,
    input  logic [DW-1:0] i_mem_data,
    input  logic [DW-1:0] i_mem_dmem,
    output logic          o_dm_req,
    output logic          o_dm_we,
    output logic [AW-1:0] o_dm_addr,
    output logic [3:0]    o_dm_be,
    output logic [DW-1:0] o_dm_wdata,
    input  logic          i_dm_gnt,
    input  logic          i_dm_rvalid,
    input  logic [DW-1:0] i_dm_rdata,
    output logic          o_stall,
    output logic          o_wb_wreg,
    output logic          o_wb_mem2reg,
    output logic [4:0]    o_wb_rd,
    output logic [DW-1:0] o_wb_alu,
    output logic [DW-1:0] o_wb_load
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic          o_wb_misalign
`endif
);

    state_e        state_q, state_d;
    size_e         size;
    logic [1:0]    off;
    logic          op, mis;
    logic          req, stall, cap, cap_ld;
    logic [DW-1:0] ld_data;

    logic          wreg_q, m2r_q;
    logic [4:0]    rd_q;
    logic [DW-1:0] alu_q, load_q;

    assign op   = i_mem_wmem | i_mem_mem2reg;
    assign off  = i_mem_data[1:0];
    assign size = dec_size(i_mem_lsb, i_mem_lsh);

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis = op & (((size == SZ_H) & off[0]) |
                       ((size == SZ_W) & (off != 2'b00)));
`else
    assign mis = 1'b0;
`endif

    mem_lane_align u_align (
        .size_i    (size),
        .off_i     (off),
        .signext_i (i_mem_loadsignext),
        .data_be_i (i_data_be),
        .dmem_i    (i_mem_dmem),
        .rdata_i   (i_dm_rdata),
        .wdata_o   (o_dm_wdata),
        .be_o      (o_dm_be),
        .load_o    (ld_data)
    );

    assign o_dm_we   = i_mem_wmem;
    assign o_dm_addr = {i_mem_data[AW-1:2], 2'b00};
    // Request and stall are masked so nothing escapes while reset is held.
    assign o_dm_req  = req & i_resetn;
    assign o_stall   = stall & i_resetn;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        stall   = 1'b0;
        cap     = 1'b0;
        cap_ld  = 1'b0;
        unique case (state_q)
            IDLE, WAIT_GNT: begin
                if (mis) begin
                    cap     = 1'b1;
                    state_d = IDLE;
                end else if (op) begin
                    req = 1'b1;
                    if (i_dm_gnt && i_mem_wmem) begin
                        cap     = 1'b1;
                        state_d = IDLE;
                    end else if (i_dm_gnt) begin
                        stall   = 1'b1;
                        state_d = WAIT_RD;
                    end else begin
                        stall   = 1'b1;
                        state_d = WAIT_GNT;
                    end
                end else begin
                    cap     = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_RD: begin
                stall = 1'b1;
                if (i_dm_rvalid) begin
                    stall   = 1'b0;
                    cap     = 1'b1;
                    cap_ld  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stalled cycles push a bubble; payload fields hold their last value.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            wreg_q <= 1'b0;
            m2r_q  <= 1'b0;
            rd_q   <= '0;
            alu_q  <= '0;
            load_q <= '0;
        end else if (cap) begin
            wreg_q <= i_mem_wreg & ~mis;
            m2r_q  <= i_mem_mem2reg;
            rd_q   <= i_mem_rd;
            alu_q  <= i_mem_data;
            if (cap_ld) begin
                load_q <= ld_data;
            end
        end else begin
            wreg_q <= 1'b0;
            m2r_q  <= 1'b0;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_q;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= cap & mis;
        end
    end

    assign o_wb_misalign = mis_q;
`endif

    assign o_wb_wreg    = wreg_q;
    assign o_wb_mem2reg = m2r_q;
    assign o_wb_rd      = rd_q;
    assign o_wb_alu     = alu_q;
    assign o_wb_load    = load_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus random traffic
// checked against a byte-addressed memory model.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_mem_mem2reg, i_mem_wmem, i_mem_wreg, i_mem_loadsignext;
    logic        i_mem_lsb, i_mem_lsh;
    logic [3:0]  i_data_be;
    logic [4:0]  i_mem_rd;
    logic [31:0] i_mem_data, i_mem_dmem;
    logic        o_dm_req, o_dm_we;
    logic [31:0] o_dm_addr;
    logic [3:0]  o_dm_be;
    logic [31:0] o_dm_wdata;
    logic        i_dm_gnt, i_dm_rvalid;
    logic [31:0] i_dm_rdata;
    logic        o_stall, o_wb_wreg, o_wb_mem2reg;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_alu, o_wb_load;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        o_wb_misalign;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] mb [int unsigned];

    logic        r_req0, r_we0, r_wreg, r_m2r, r_to;
    logic [31:0] r_a0, r_wd0, r_alu, r_load;
    logic [3:0]  r_be0;
    logic [4:0]  r_rd;
    int          r_stalls, r_late, r_bub;

    mem_access_stage dut (
        .i_clk             (clk),
        .i_resetn          (resetn),
        .i_mem_mem2reg     (i_mem_mem2reg),
        .i_mem_wmem        (i_mem_wmem),
        .i_mem_wreg        (i_mem_wreg),
        .i_mem_loadsignext (i_mem_loadsignext),
        .i_mem_lsb         (i_mem_lsb),
        .i_mem_lsh         (i_mem_lsh),
        .i_data_be         (i_data_be),
        .i_mem_rd          (i_mem_rd),
        .i_mem_data        (i_mem_data),
        .i_mem_dmem        (i_mem_dmem),
        .o_dm_req          (o_dm_req),
        .o_dm_we           (o_dm_we),
        .o_dm_addr         (o_dm_addr),
        .o_dm_be           (o_dm_be),
        .o_dm_wdata        (o_dm_wdata),
        .i_dm_gnt          (i_dm_gnt),
        .i_dm_rvalid       (i_dm_rvalid),
        .i_dm_rdata        (i_dm_rdata),
        .o_stall           (o_stall),
        .o_wb_wreg         (o_wb_wreg),
        .o_wb_mem2reg      (o_wb_mem2reg),
        .o_wb_rd           (o_wb_rd),
        .o_wb_alu          (o_wb_alu),
        .o_wb_load         (o_wb_load)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .o_wb_misalign     (o_wb_misalign)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rd_byte(input int unsigned a);
        if (!mb.exists(a)) mb[a] = 8'($urandom);
        return mb[a];
    endfunction

    task automatic idle_inputs();
        i_mem_mem2reg = 0; i_mem_wmem = 0; i_mem_wreg = 0;
        i_mem_loadsignext = 0; i_mem_lsb = 0; i_mem_lsh = 0;
        i_data_be = 4'hF; i_mem_rd = 0; i_mem_data = 0; i_mem_dmem = 0;
        i_dm_gnt = 0; i_dm_rvalid = 0; i_dm_rdata = 0;
    endtask

    // Drives one instruction from a negedge, acts as the memory and
    // returns what was observed; the caller judges the results.
    task automatic run_op(
        input logic we, input logic ld, input logic wreg, input logic sx,
        input logic lsb, input logic lsh, input logic [3:0] dbe,
        input logic [4:0] rd, input logic [31:0] addr,
        input logic [31:0] dmem, input logic [31:0] rdata,
        input int gdly, input int rdly);
        bit ph, done;
        int rvc;
        ph = 0; done = 0; rvc = -1;
        r_stalls = 0; r_late = 0; r_bub = 0; r_to = 1;
        i_mem_wmem = we; i_mem_mem2reg = ld; i_mem_wreg = wreg;
        i_mem_loadsignext = sx; i_mem_lsb = lsb; i_mem_lsh = lsh;
        i_data_be = dbe; i_mem_rd = rd; i_mem_data = addr; i_mem_dmem = dmem;
        for (int k = 0; k < 30; k++) begin
            i_dm_gnt    = !ph && (we || ld) && (k == gdly);
            i_dm_rvalid = ph && (k == rvc);
            i_dm_rdata  = i_dm_rvalid ? rdata : $urandom;
            #1;
            if (k == 0) begin
                r_req0 = o_dm_req; r_we0 = o_dm_we; r_a0 = o_dm_addr;
                r_be0 = o_dm_be; r_wd0 = o_dm_wdata;
            end
            if (o_stall) r_stalls++;
            if (ph && o_dm_req) r_late++;
            if (!(we || ld)) done = 1;
            else if (!ph && i_dm_gnt) begin
                if (we) done = 1;
                else begin ph = 1; rvc = k + 1 + rdly; end
            end else if (ph && i_dm_rvalid) done = 1;
            @(negedge clk);
            if (done) begin
                r_wreg = o_wb_wreg; r_m2r = o_wb_mem2reg; r_rd = o_wb_rd;
                r_alu = o_wb_alu; r_load = o_wb_load; r_to = 0;
                break;
            end
            if (o_wb_wreg) r_bub++;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 0;
        i_mem_mem2reg = 1;
        @(negedge clk); @(negedge clk);
        total++; if (o_dm_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", o_dm_req); end
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", o_stall); end
        total++; if ({o_wb_wreg, o_wb_mem2reg, o_wb_rd} !== 7'd0) begin bad++; $display("FAIL rst_wb_ctl: got %b%b %h want 0", o_wb_wreg, o_wb_mem2reg, o_wb_rd); end
        total++; if ({o_wb_alu, o_wb_load} !== 64'd0) begin bad++; $display("FAIL rst_wb_data: got %h %h want 0", o_wb_alu, o_wb_load); end
        idle_inputs();
        resetn = 1;
        @(negedge clk);
    endtask

    task automatic test_store_byte();
        run_op(1, 0, 0, 0, 1, 0, 4'hF, 5'd3, 32'h1003, 32'h000000A5, 0, 0, 0);
        total++; if (r_to) begin bad++; $display("FAIL sb_timeout: got 1 want 0"); end
        total++; if (r_req0 !== 1'b1) begin bad++; $display("FAIL sb_req: got %b want 1", r_req0); end
        total++; if (r_we0 !== 1'b1) begin bad++; $display("FAIL sb_we: got %b want 1", r_we0); end
        total++; if (r_a0 !== 32'h1000) begin bad++; $display("FAIL sb_addr: got %h want 1000", r_a0); end
        total++; if (r_be0 !== 4'b1000) begin bad++; $display("FAIL sb_be: got %b want 1000", r_be0); end
        total++; if (r_wd0 !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_wdata: got %h want a5a5a5a5", r_wd0); end
        total++; if (r_stalls !== 0) begin bad++; $display("FAIL sb_stall: got %0d want 0", r_stalls); end
        total++; if (r_wreg !== 1'b0) begin bad++; $display("FAIL sb_wreg: got %b want 0", r_wreg); end
    endtask

    task automatic test_load_half();
        run_op(0, 1, 1, 1, 0, 1, 4'hF, 5'd13, 32'h2002, 0, 32'h80011234, 2, 1);
        total++; if (r_to) begin bad++; $display("FAIL lh_timeout: got 1 want 0"); end
        total++; if (r_stalls !== 4) begin bad++; $display("FAIL lh_stall: got %0d want 4", r_stalls); end
        total++; if (r_be0 !== 4'b1100) begin bad++; $display("FAIL lh_be: got %b want 1100", r_be0); end
        total++; if (r_we0 !== 1'b0) begin bad++; $display("FAIL lh_we: got %b want 0", r_we0); end
        total++; if (r_load !== 32'hFFFF8001) begin bad++; $display("FAIL lh_load: got %h want ffff8001", r_load); end
        total++; if (r_wreg !== 1'b1) begin bad++; $display("FAIL lh_wreg: got %b want 1", r_wreg); end
        total++; if (r_m2r !== 1'b1) begin bad++; $display("FAIL lh_m2r: got %b want 1", r_m2r); end
        total++; if (r_rd !== 5'd13) begin bad++; $display("FAIL lh_rd: got %0d want 13", r_rd); end
        total++; if (r_alu !== 32'h2002) begin bad++; $display("FAIL lh_alu: got %h want 2002", r_alu); end
        total++; if (r_late !== 0) begin bad++; $display("FAIL lh_req_in_rd: got %0d want 0", r_late); end
        total++; if (r_bub !== 0) begin bad++; $display("FAIL lh_bubble: got %0d want 0", r_bub); end
    endtask

    task automatic test_load_byte();
        run_op(0, 1, 1, 0, 1, 0, 4'hF, 5'd9, 32'h0001, 0, 32'h0000F000, 0, 0);
        total++; if (r_load !== 32'h000000F0) begin bad++; $display("FAIL lbu_load: got %h want 000000f0", r_load); end
        total++; if (r_be0 !== 4'b0010) begin bad++; $display("FAIL lbu_be: got %b want 0010", r_be0); end
        total++; if (r_stalls !== 1) begin bad++; $display("FAIL lbu_stall: got %0d want 1", r_stalls); end
    endtask

    task automatic test_alu();
        run_op(0, 0, 1, 0, 0, 0, 4'hF, 5'd7, 32'h55, 32'hDEAD, 0, 0, 0);
        total++; if (r_req0 !== 1'b0) begin bad++; $display("FAIL alu_req: got %b want 0", r_req0); end
        total++; if (r_stalls !== 0) begin bad++; $display("FAIL alu_stall: got %0d want 0", r_stalls); end
        total++; if (r_alu !== 32'h55) begin bad++; $display("FAIL alu_val: got %h want 55", r_alu); end
        total++; if (r_rd !== 5'd7) begin bad++; $display("FAIL alu_rd: got %0d want 7", r_rd); end
        total++; if (r_wreg !== 1'b1) begin bad++; $display("FAIL alu_wreg: got %b want 1", r_wreg); end
    endtask

    task automatic test_both_sizes();
        run_op(1, 0, 0, 0, 1, 1, 4'hF, 5'd1, 32'h0002, 32'h123456C3, 0, 1, 0);
        total++; if (r_be0 !== 4'b0100) begin bad++; $display("FAIL bh_be: got %b want 0100", r_be0); end
        total++; if (r_wd0 !== 32'hC3C3C3C3) begin bad++; $display("FAIL bh_wdata: got %h want c3c3c3c3", r_wd0); end
        total++; if (r_stalls !== 1) begin bad++; $display("FAIL bh_stall: got %0d want 1", r_stalls); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            int kind, nb, off, gd, rdl;
            logic we, ld, sx, wreg;
            logic [4:0] rd;
            logic [3:0] dbe, ebe;
            logic [31:0] base, addr, d, ewd, rdata, exp;
            kind = $urandom_range(0, 6);
            we = kind inside {[1:3]};
            ld = kind inside {[4:6]};
            nb = (kind == 1 || kind == 4) ? 1 : (kind == 2 || kind == 5) ? 2 : 4;
            base = 32'($urandom_range(0, 15) * 4);
            off = (nb == 1) ? $urandom_range(0, 3) : (nb == 2) ? 2 * $urandom_range(0, 1) : 0;
            addr = (we || ld) ? base + 32'(off) : $urandom;
            d = $urandom; sx = 1'($urandom); wreg = 1'($urandom); rd = 5'($urandom);
            gd = $urandom_range(0, 3); rdl = $urandom_range(0, 2);
            dbe = (kind == 3) ? 4'($urandom_range(1, 15)) : 4'hF;
            ebe = (nb == 1) ? 4'(1 << off) : (nb == 2) ? 4'(3 << off) : dbe;
            ewd = (nb == 1) ? {4{d[7:0]}} : (nb == 2) ? {2{d[15:0]}} : d;
            rdata = 0; exp = 0;
            if (ld) begin
                for (int j = 0; j < 4; j++) rdata[8*j +: 8] = rd_byte(base + j);
                for (int j = 0; j < nb; j++) exp[8*j +: 8] = rd_byte(addr + j);
                if (nb == 1 && sx) exp = {{24{exp[7]}}, exp[7:0]};
                if (nb == 2 && sx) exp = {{16{exp[15]}}, exp[15:0]};
            end
            if (we) begin
                if (nb == 4) begin
                    for (int j = 0; j < 4; j++) if (dbe[j]) mb[base + j] = d[8*j +: 8];
                end else begin
                    for (int j = 0; j < nb; j++) mb[addr + j] = d[8*j +: 8];
                end
            end
            run_op(we, ld, wreg, sx, nb == 1, nb == 2, dbe, rd, addr, d, rdata, gd, rdl);
            total++; if (r_to) begin bad++; $display("FAIL rnd%0d_timeout: got 1 want 0", n); end
            total++; if (r_req0 !== (we | ld)) begin bad++; $display("FAIL rnd%0d_req: got %b want %b", n, r_req0, we | ld); end
            total++; if (r_stalls !== (ld ? gd + 1 + rdl : we ? gd : 0)) begin bad++; $display("FAIL rnd%0d_stall: got %0d", n, r_stalls); end
            total++; if (r_wreg !== wreg) begin bad++; $display("FAIL rnd%0d_wreg: got %b want %b", n, r_wreg, wreg); end
            total++; if (r_rd !== rd) begin bad++; $display("FAIL rnd%0d_rd: got %0d want %0d", n, r_rd, rd); end
            total++; if (r_alu !== addr) begin bad++; $display("FAIL rnd%0d_alu: got %h want %h", n, r_alu, addr); end
            total++; if (r_bub !== 0 || r_late !== 0) begin bad++; $display("FAIL rnd%0d_bubble: got %0d/%0d want 0/0", n, r_bub, r_late); end
            if (we || ld) begin
                total++; if (r_be0 !== ebe) begin bad++; $display("FAIL rnd%0d_be: got %b want %b", n, r_be0, ebe); end
                total++; if (r_a0 !== base) begin bad++; $display("FAIL rnd%0d_addr: got %h want %h", n, r_a0, base); end
                total++; if (r_we0 !== we) begin bad++; $display("FAIL rnd%0d_we: got %b want %b", n, r_we0, we); end
            end
            if (we) begin
                total++; if (r_wd0 !== ewd) begin bad++; $display("FAIL rnd%0d_wdata: got %h want %h", n, r_wd0, ewd); end
            end
            if (ld) begin
                total++; if (r_load !== exp) begin bad++; $display("FAIL rnd%0d_load: got %h want %h", n, r_load, exp); end
                total++; if (r_m2r !== 1'b1) begin bad++; $display("FAIL rnd%0d_m2r: got %b want 1", n, r_m2r); end
            end
        end
    endtask

    task automatic test_reset_mid();
        i_mem_mem2reg = 1; i_mem_wreg = 1; i_mem_rd = 5'd4; i_mem_data = 32'h40;
        i_dm_gnt = 1;
        @(negedge clk);
        i_dm_gnt = 0;
        #1;
        total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL rmid_wait: got %b want 1", o_stall); end
        resetn = 0;
        #1;
        total++; if (o_stall !== 1'b0 || o_dm_req !== 1'b0) begin bad++; $display("FAIL rmid_drop: got stall=%b req=%b want 0/0", o_stall, o_dm_req); end
        idle_inputs();
        @(negedge clk);
        resetn = 1;
        @(negedge clk);
        i_dm_rvalid = 1; i_dm_rdata = 32'hDEADBEEF;
        #1;
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL rmid_stall: got %b want 0", o_stall); end
        @(negedge clk);
        i_dm_rvalid = 0;
        total++; if (o_wb_load !== 32'h0) begin bad++; $display("FAIL rmid_load: got %h want 0", o_wb_load); end
        total++; if ({o_wb_wreg, o_wb_mem2reg, o_wb_rd, o_wb_alu} !== 39'd0) begin bad++; $display("FAIL rmid_wb: got %b%b %h %h want 0", o_wb_wreg, o_wb_mem2reg, o_wb_rd, o_wb_alu); end
    endtask

`ifdef MEM_MISALIGN_TRAP_EN
    task automatic test_misalign();
        i_mem_mem2reg = 1; i_mem_wreg = 1; i_mem_rd = 5'd2; i_mem_data = 32'h6;
        #1;
        total++; if (o_dm_req !== 1'b0 || o_stall !== 1'b0) begin bad++; $display("FAIL mis_req: got req=%b stall=%b want 0/0", o_dm_req, o_stall); end
        @(negedge clk);
        idle_inputs();
        total++; if (o_wb_misalign !== 1'b1) begin bad++; $display("FAIL mis_flag: got %b want 1", o_wb_misalign); end
        total++; if (o_wb_wreg !== 1'b0) begin bad++; $display("FAIL mis_wreg: got %b want 0", o_wb_wreg); end
        @(negedge clk);
        total++; if (o_wb_misalign !== 1'b0) begin bad++; $display("FAIL mis_clear: got %b want 0", o_wb_misalign); end
    endtask
`endif

    initial begin
        test_reset();
        test_store_byte();
        test_load_half();
        test_load_byte();
        test_alu();
        test_both_sizes();
        test_random();
        test_reset_mid();
`ifdef MEM_MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
